// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, memory geometry and fetch state encoding.
package mips_pkg;

  localparam int IMEM_DEPTH = 128;
  localparam logic [5:0] OP_J = 6'b000010;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  function automatic logic is_jump(input logic [31:0] word);
    return (word[31:26] == OP_J);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory port owner: boot-time loader writes, then sequential fetch
// with stall hold, external redirect and self-detected j instructions.
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_we,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic          inst_valid
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  inst_pc_r;
  logic         inst_valid_r;
  logic         take_jump_s;

  // A j is only acted on once decode has actually accepted it.
  assign take_jump_s = inst_valid_r && !stall && is_jump(imem_rdata);

  assign inst       = imem_rdata;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = inst_valid_r;

  // Memory port mux: loader owns the port in BOOT, fetch owns it in RUN.
  always_comb begin
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = 32'd0;
    imem_addr  = {AW{1'b0}};
    case (state_r)
      BOOT: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          imem_we    = 1'b1;
          imem_addr  = ld_addr;
          imem_wdata = ld_data;
        end else begin
          imem_we    = 1'b0;
          imem_addr  = {AW{1'b0}};
          imem_wdata = 32'd0;
        end
      end
      RUN: begin
        // Re-reading the held word keeps imem_rdata (and so inst) stable.
        if (stall && !redirect_valid) begin
          imem_addr = inst_pc_r[AW-1:0];
        end else begin
          imem_addr = pc_r[AW-1:0];
        end
      end
      default: begin
        imem_addr = {AW{1'b0}};
      end
    endcase
  end

  // Fetch sequencer: state, PC and the registered instruction tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= BOOT;
      pc_r         <= 32'd0;
      inst_pc_r    <= 32'd0;
      inst_valid_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          pc_r         <= 32'd0;
          inst_valid_r <= 1'b0;
          if (go) begin
            state_r <= RUN;
          end else begin
            state_r <= BOOT;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc_r         <= redirect_pc;
            inst_valid_r <= 1'b0;
          end else if (take_jump_s) begin
            pc_r         <= {6'd0, imem_rdata[25:0]};
            inst_valid_r <= 1'b0;
          end else if (stall) begin
            pc_r         <= pc_r;
            inst_valid_r <= inst_valid_r;
          end else begin
            inst_pc_r    <= pc_r;
            inst_valid_r <= 1'b1;
            pc_r         <= pc_r + 32'd1;
          end
        end
        default: begin
          state_r      <= BOOT;
          pc_r         <= 32'd0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller that owns the 128-word instruction memory port. After reset it lets a boot loader write the program. On a start pulse it sequences a word-indexed PC through the memory and presents fetched instructions with their PC. It also handles stalls, external redirects (branch/jump from later stages) and self-detected `j` instructions. It sits between the instruction memory and the decode stage of the MIPS pipeline.

## Interface
- `DEPTH`, 128, instruction memory depth in 32-bit words.
- `AW`, 7, memory address width; log2(`DEPTH`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  single-cycle pulse; leaves BOOT and starts fetching at PC 0.
- `ld_valid`  in  1  loader write request.
- `ld_ready`  out  1  loader write accepted this cycle.
- `ld_addr`  in  AW  loader word address.
- `ld_data`  in  32  loader write data.
- `stall`  in  1  decode cannot accept; hold the current instruction.
- `redirect_valid`  in  1  external PC redirect.
- `redirect_pc`  in  32  redirect target as a word index.
- `imem_addr`  out  AW  memory address.
- `imem_we`  out  1  memory write enable.
- `imem_wdata`  out  32  memory write data.
- `imem_rdata`  in  32  memory read data; synchronous, valid the cycle after the address.
- `inst`  out  32  fetched instruction; equal to `imem_rdata`.
- `inst_pc`  out  32  word PC of `inst`.
- `inst_valid`  out  1  `inst` is architecturally valid.

## Operation
- States: BOOT and RUN.
  - Reset enters BOOT from any state, including mid-fetch.
  - BOOT goes to RUN when `go`=1.
  - RUN leaves only on `rst`.
- BOOT:
  - `ld_ready`=1.
  - When `ld_valid`=1: `imem_we`=1, `imem_addr`=`ld_addr`, `imem_wdata`=`ld_data`.
  - `inst_valid`=0.
  - `go` together with `ld_valid` in the same cycle: the write completes; fetch starts the next cycle.
- RUN:
  - `ld_ready`=0, `imem_we`=0. Loader requests are ignored (no write, no ack).
  - Fetch PC register `pc` is 32 bits. Issue `imem_addr` = `pc[AW-1:0]`, then `pc` <= `pc`+1.
  - Each issued fetch sets `inst_pc` <= issued PC and `inst_valid` <= 1 for the next cycle.
- Wrap-around: addresses above `DEPTH`-1 alias modulo `DEPTH`. `pc` itself is not truncated; `inst_pc` reports the full 32-bit value.
- Stall (RUN, `stall`=1, no redirect):
  - `pc` holds.
  - `imem_addr` = `inst_pc[AW-1:0]`, so the same word is re-read.
  - `inst`, `inst_pc` and `inst_valid` stay unchanged.
- Self jump:
  - Condition: `inst_valid`=1, `stall`=0 and `inst[31:26]`=6'b000010.
  - Effect: `pc` <= {6'b0, `inst[25:0]`}. The fetch issued this cycle is squashed (`inst_valid`=0 next cycle).
- External redirect:
  - `redirect_valid`=1 in RUN sets `pc` <= `redirect_pc` and squashes the in-flight fetch.
  - Applies even while `stall`=1; the stall hold is released for that cycle.
  - Priority: `rst` > `redirect_valid` > self jump > stall > sequential increment.
- `redirect_valid` and `go` in BOOT: redirect ignored; fetch starts at 0.

## Timing
- Reset values:
  - state BOOT, `pc` 0.
  - `inst_pc` 0, `inst_valid` 0.
  - `imem_we` 0, `imem_wdata` 0, `imem_addr` 0.
  - `ld_ready` 1 from the first cycle after reset.
- `go` at cycle t: address 0 issued at t+1. `inst_valid`=1 with `inst_pc`=0 at t+2, then one instruction per cycle.
- Redirect or jump at cycle t: `inst_valid`=0 at t+1, target issued at t+1, target valid at t+2. Penalty is one bubble.
- Loader write: one cycle, zero latency. `ld_ready` is combinational from state.
- `stall` is sampled the same cycle. Outputs at t+1 equal outputs at t.

## Structure
- Shared package `mips_pkg` holds:
  - `OP_J` = 6'b000010.
  - `IMEM_DEPTH` = 128.
  - the state enum {BOOT, RUN}.
- Single module; no sub-module. The memory itself stays external.

## Test plan
- Boot load: reset, write words 0..3 through the loader with `ld_valid`=1 each cycle, pulse `go` -> `inst_pc` 0,1,2,3 on consecutive cycles with the matching data, `inst_valid`=1 from cycle `go`+2.
- Stall: hold `stall`=1 for 3 cycles while `inst_pc`=2 -> `inst_pc`=2 and `inst` constant; resume -> `inst_pc`=3 next.
- Self jump: load word 1 = 32'h08000005 -> `inst_pc` sequence 0,1, bubble (`inst_valid`=0), 5,6.
- Redirect during stall: `stall`=1 with `redirect_valid`=1, `redirect_pc`=10 -> bubble, then `inst_pc`=10; redirect beats a simultaneous jump.
- Wrap: `redirect_pc`=127 -> `inst_pc` 127 then 128, with `imem_addr`=0 and data of word 0.
- Reset mid-run: assert `rst` during RUN -> next cycle `inst_valid`=0, `ld_ready`=1, `pc`=0; loader writes accepted again.
